// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter shared definitions
// State codes, default widths and the round-robin pick.
package ram_port_arbiter_pkg;

  localparam int DEF_ADDR_SIZE      = 13;
  localparam int DEF_CASH_STR_WIDTH = 64;
  localparam int DEF_CNT_WIDTH      = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Lone requester wins; on a tie the port not served last wins
  function automatic logic pick_winner(
    input logic r0,
    input logic r1,
    input logic last
  );
    logic w;
    if (r0 && r1) begin
      w = ~last;
    end else begin
      w = r1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter request/response bus
// master issues addr/wdata/rnw/avalid, slave returns rdata/ack.
interface ram_port_arbiter_if
  import ram_port_arbiter_pkg::*;
#(
  parameter int AW = DEF_ADDR_SIZE,
  parameter int DW = DEF_CASH_STR_WIDTH
);

  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          rnw;
  logic          avalid;
  logic [DW-1:0] rdata;
  logic          ack;

  modport master (
    output addr, wdata, rnw, avalid,
    input  rdata, ack
  );

  modport slave (
    input  addr, wdata, rnw, avalid,
    output rdata, ack
  );

endinterface

// File: rtl/ram_port_arbiter_sat_counter.sv
// ram_port_arbiter saturating grant counter
// clr wins over inc; holds at all-ones.
module ram_port_arbiter_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         not_reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: clear, saturating increment or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two cache requesters share one RAM port
// Round-robin pick, registered request, one-cycle ack to winner.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_SIZE      = DEF_ADDR_SIZE,
  parameter int CASH_STR_WIDTH = DEF_CASH_STR_WIDTH,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 not_reset,
  ram_port_arbiter_if.slave    p0,
  ram_port_arbiter_if.slave    p1,
  ram_port_arbiter_if.master   mem,
  output logic                 busy,
  output logic                 grant_id,
  output logic [CNT_WIDTH-1:0] p0_grants,
  output logic [CNT_WIDTH-1:0] p1_grants,
  input  logic                 cnt_clear,
  output logic                 spurious_ack
);

  logic [1:0]                state_q, state_d;
  logic                      last_q, last_d;
  logic                      gid_q, gid_d;
  logic [ADDR_SIZE-1:0]      addr_q, addr_d;
  logic [CASH_STR_WIDTH-1:0] wdata_q, wdata_d;
  logic                      rnw_q, rnw_d;
  logic [CASH_STR_WIDTH-1:0] rdata_q, rdata_d;
  logic                      spur_q, spur_d;

  logic req_any;
  logic win;
  logic resp0;
  logic resp1;

  assign req_any = p0.avalid | p1.avalid;
  assign win     = pick_winner(p0.avalid, p1.avalid, last_q);

  // FSM and request/response register next-state
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rnw_d   = rnw_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          gid_d   = win;
          addr_d  = win ? p1.addr  : p0.addr;
          wdata_d = win ? p1.wdata : p0.wdata;
          rnw_d   = win ? p1.rnw   : p0.rnw;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem.ack) begin
          rdata_d = rnw_q ? mem.rdata : '0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        last_d  = gid_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // sticky flag for acks that arrive with no transfer pending
  always_comb begin
    spur_d = spur_q;
    if (cnt_clear) begin
      spur_d = 1'b0;
    end else if (mem.ack && (state_q != ST_WAIT)) begin
      spur_d = 1'b1;
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      gid_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rnw_q   <= 1'b0;
      rdata_q <= '0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rnw_q   <= rnw_d;
      rdata_q <= rdata_d;
      spur_q  <= spur_d;
    end
  end

  assign resp0 = (state_q == ST_RESP) && !gid_q;
  assign resp1 = (state_q == ST_RESP) &&  gid_q;

  assign mem.avalid = (state_q == ST_WAIT);
  assign mem.addr   = addr_q;
  assign mem.wdata  = wdata_q;
  assign mem.rnw    = rnw_q;

  assign p0.ack   = resp0;
  assign p1.ack   = resp1;
  assign p0.rdata = resp0 ? rdata_q : '0;
  assign p1.rdata = resp1 ? rdata_q : '0;

  assign busy         = (state_q != ST_IDLE);
  assign grant_id     = gid_q;
  assign spurious_ack = spur_q;

  ram_port_arbiter_sat_counter #(
    .W(CNT_WIDTH)
  ) u_cnt0 (
    .clk       (clk),
    .not_reset (not_reset),
    .inc       (resp0),
    .clr       (cnt_clear),
    .cnt       (p0_grants)
  );

  ram_port_arbiter_sat_counter #(
    .W(CNT_WIDTH)
  ) u_cnt1 (
    .clk       (clk),
    .not_reset (not_reset),
    .inc       (resp1),
    .clr       (cnt_clear),
    .cnt       (p1_grants)
  );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: random + directed bench
// Transaction-level model compared every cycle.
`timescale 1ns/1ps
module tb_ram_port_arbiter;

  localparam int AW = 13;
  localparam int DW = 64;
  localparam int CW = 16;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic not_reset;
  logic cnt_clear = 1'b0;

  logic [AW-1:0] a [2];
  logic [DW-1:0] wd [2];
  logic          rw [2];
  logic          av [2];
  logic          mack = 1'b0;
  logic [DW-1:0] mrd = '0;

  logic          busy, gid, spur;
  logic [CW-1:0] g0, g1;
  logic          sbusy, sgid, sspur;
  logic [SW-1:0] sg0, sg1;

  always #5 clk = ~clk;

  ram_port_arbiter_if #(.AW(AW), .DW(DW)) p0_if ();
  ram_port_arbiter_if #(.AW(AW), .DW(DW)) p1_if ();
  ram_port_arbiter_if #(.AW(AW), .DW(DW)) mem_if ();
  ram_port_arbiter_if #(.AW(AW), .DW(DW)) p0s_if ();
  ram_port_arbiter_if #(.AW(AW), .DW(DW)) p1s_if ();
  ram_port_arbiter_if #(.AW(AW), .DW(DW)) mems_if ();

  assign p0_if.addr    = a[0];
  assign p0_if.wdata   = wd[0];
  assign p0_if.rnw     = rw[0];
  assign p0_if.avalid  = av[0];
  assign p1_if.addr    = a[1];
  assign p1_if.wdata   = wd[1];
  assign p1_if.rnw     = rw[1];
  assign p1_if.avalid  = av[1];
  assign mem_if.ack    = mack;
  assign mem_if.rdata  = mrd;
  assign p0s_if.addr   = a[0];
  assign p0s_if.wdata  = wd[0];
  assign p0s_if.rnw    = rw[0];
  assign p0s_if.avalid = av[0];
  assign p1s_if.addr   = a[1];
  assign p1s_if.wdata  = wd[1];
  assign p1s_if.rnw    = rw[1];
  assign p1s_if.avalid = av[1];
  assign mems_if.ack   = mack;
  assign mems_if.rdata = mrd;

  ram_port_arbiter #(
    .ADDR_SIZE(AW), .CASH_STR_WIDTH(DW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .not_reset(not_reset),
    .p0(p0_if), .p1(p1_if), .mem(mem_if),
    .busy(busy), .grant_id(gid),
    .p0_grants(g0), .p1_grants(g1),
    .cnt_clear(cnt_clear), .spurious_ack(spur)
  );

  ram_port_arbiter #(
    .ADDR_SIZE(AW), .CASH_STR_WIDTH(DW), .CNT_WIDTH(SW)
  ) dut_s (
    .clk(clk), .not_reset(not_reset),
    .p0(p0s_if), .p1(p1s_if), .mem(mems_if),
    .busy(sbusy), .grant_id(sgid),
    .p0_grants(sg0), .p1_grants(sg1),
    .cnt_clear(cnt_clear), .spurious_ack(sspur)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: one outstanding transfer, described as a record
  bit            m_act, m_resp, m_own, m_last, m_spur;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  bit            m_rnw;
  int            m_n [2];

  // bench agents
  bit   auto_en = 0, hold = 0, spur_en = 0, clr_en = 0;
  bit   rd_fixed = 0, picked = 0;
  logic [DW-1:0] rd_val = '0;
  int   mem_lat = 0, lat = 0, wcnt = 0;
  int   left [2], ack_cnt [2];
  bit   cool [2];
  int   overlap = 0, av_cycles = 0;
  int   served [$];

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [63:0] sat(int n, int w);
    logic [63:0] mx;
    mx = (64'd1 << w) - 64'd1;
    if (64'(n) > mx) return mx;
    return 64'(n);
  endfunction

  function automatic void m_reset();
    m_act = 0; m_resp = 0; m_own = 0; m_last = 1; m_spur = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_rnw = 0;
    m_n[0] = 0; m_n[1] = 0;
  endfunction

  function automatic void m_step();
    if (!not_reset) begin
      m_reset();
      return;
    end
    if (m_resp) begin
      m_n[m_own]++;
      m_last = m_own;
      m_resp = 0;
      m_act  = 0;
      if (mack) m_spur = 1;
    end else if (m_act) begin
      if (mack) begin
        m_rdata = m_rnw ? mrd : '0;
        m_resp  = 1;
      end
    end else begin
      if (mack) m_spur = 1;
      if (av[0] || av[1]) begin
        m_own   = (av[0] && av[1]) ? !m_last : av[1];
        m_addr  = a[m_own];
        m_wdata = wd[m_own];
        m_rnw   = rw[m_own];
        m_act   = 1;
      end
    end
    if (cnt_clear) begin
      m_n[0] = 0; m_n[1] = 0; m_spur = 0;
    end
  endfunction

  function automatic void compare_all();
    bit e_av, e_a0, e_a1;
    e_av = m_act && !m_resp;
    e_a0 = m_resp && !m_own;
    e_a1 = m_resp && m_own;
    chk("mem_avalid", 64'(mem_if.avalid), 64'(e_av));
    chk("mem_addr", 64'(mem_if.addr), 64'(m_addr));
    chk("mem_wdata", mem_if.wdata, m_wdata);
    chk("mem_rnw", 64'(mem_if.rnw), 64'(m_rnw));
    chk("p0_ack", 64'(p0_if.ack), 64'(e_a0));
    chk("p1_ack", 64'(p1_if.ack), 64'(e_a1));
    chk("p0_rdata", p0_if.rdata, e_a0 ? m_rdata : '0);
    chk("p1_rdata", p1_if.rdata, e_a1 ? m_rdata : '0);
    chk("busy", 64'(busy), 64'(m_act));
    chk("grant_id", 64'(gid), 64'(m_own));
    chk("p0_grants", 64'(g0), sat(m_n[0], CW));
    chk("p1_grants", 64'(g1), sat(m_n[1], CW));
    chk("p0_grants_w2", 64'(sg0), sat(m_n[0], SW));
    chk("p1_grants_w2", 64'(sg1), sat(m_n[1], SW));
    chk("spurious_ack", 64'(spur), 64'(m_spur));
    chk("spurious_ack_w2", 64'(sspur), 64'(m_spur));
  endfunction

  function automatic void observe();
    if (p0_if.ack === 1'b1) begin
      served.push_back(0);
      ack_cnt[0]++;
    end
    if (p1_if.ack === 1'b1) begin
      served.push_back(1);
      ack_cnt[1]++;
    end
    if (mem_if.avalid && (p0_if.ack || p1_if.ack)) overlap++;
    if (mem_if.avalid) av_cycles++;
  endfunction

  function automatic void agents();
    for (int p = 0; p < 2; p++) begin
      if (m_resp && (int'(m_own) == p)) begin
        av[p]   = 0;
        cool[p] = 1;
      end else if (cool[p]) begin
        cool[p] = 0;
      end else if (auto_en && !av[p] && left[p] > 0 &&
                   (hold || $urandom_range(0, 3) != 0)) begin
        av[p] = 1;
        a[p]  = AW'($urandom);
        wd[p] = {$urandom, $urandom};
        rw[p] = 1'($urandom);
        left[p]--;
      end
    end
    if (mack) begin
      mack = 0;
    end else if (m_act && !m_resp) begin
      if (!picked) begin
        lat    = (mem_lat >= 0) ? mem_lat : $urandom_range(0, 3);
        wcnt   = 0;
        picked = 1;
      end
      if (wcnt >= lat) begin
        mack   = 1;
        mrd    = rd_fixed ? rd_val : {$urandom, $urandom};
        picked = 0;
      end else begin
        wcnt++;
      end
    end else if (spur_en && $urandom_range(0, 19) == 0) begin
      mack = 1;
      mrd  = {$urandom, $urandom};
    end
    if (clr_en) cnt_clear = ($urandom_range(0, 29) == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
    compare_all();
    observe();
    agents();
  endtask

  task automatic run_until(int p, int target, int lim);
    int b;
    int i;
    b = ack_cnt[p];
    i = 0;
    while (ack_cnt[p] - b < target && i < lim) begin
      tick();
      i++;
    end
    n_cmp++;
    if (ack_cnt[p] - b < target) begin
      n_bad++;
      $display("FAIL run_until_p%0d: got %0d acks, expected %0d",
               p, ack_cnt[p] - b, target);
    end
  endtask

  initial begin
    int b0, b1, i;
    for (int p = 0; p < 2; p++) begin
      a[p] = '0; wd[p] = '0; rw[p] = 0; av[p] = 0;
      left[p] = 0; ack_cnt[p] = 0; cool[p] = 0;
    end
    m_reset();
    not_reset = 1'b1;
    #2 not_reset = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant_id", 64'(gid), 64'd0);
    chk("rst_mem_avalid", 64'(mem_if.avalid), 64'd0);
    chk("rst_mem_addr", 64'(mem_if.addr), 64'd0);
    chk("rst_spur", 64'(spur), 64'd0);
    chk("rst_p0_grants", 64'(g0), 64'd0);
    not_reset = 1'b1;
    tick();

    // single read on port 0
    rd_fixed = 1;
    rd_val   = 64'h0123_4567_89AB_CDEF;
    mem_lat  = 1;
    a[0] = 13'h0A5; rw[0] = 1; wd[0] = '0; av[0] = 1;
    tick();
    chk("rd_mem_avalid", 64'(mem_if.avalid), 64'd1);
    chk("rd_mem_addr", 64'(mem_if.addr), 64'h0A5);
    chk("rd_mem_rnw", 64'(mem_if.rnw), 64'd1);
    run_until(0, 1, 10);
    chk("rd_p0_rdata", p0_if.rdata, 64'h0123_4567_89AB_CDEF);
    chk("rd_p1_ack", 64'(p1_if.ack), 64'd0);
    tick();
    chk("rd_p0_grants", 64'(g0), 64'd1);
    rd_fixed = 0;
    tick();

    // tie right after reset: port 0 first
    not_reset = 1'b0;
    tick();
    not_reset = 1'b1;
    tick();
    a[0] = 13'h011; rw[0] = 1; av[0] = 1;
    a[1] = 13'h022; rw[1] = 1; av[1] = 1;
    tick();
    chk("tie_first_gid", 64'(gid), 64'd0);
    run_until(0, 1, 10);
    run_until(1, 1, 10);
    chk("tie_second_gid", 64'(gid), 64'd1);
    tick();
    chk("tie_p0_grants", 64'(g0), 64'd1);
    chk("tie_p1_grants", 64'(g1), 64'd1);

    // sustained contention, ack latency 1
    cnt_clear = 1;
    tick();
    cnt_clear = 0;
    served.delete();
    overlap = 0;
    auto_en = 1; hold = 1; mem_lat = 1;
    left[0] = 6; left[1] = 6;
    run_until(1, 6, 300);
    tick();
    chk("alt_len", 64'(served.size()), 64'd12);
    for (int k = 0; k < served.size(); k++)
      chk("alt_order", 64'(served[k]), 64'(k % 2));
    chk("alt_overlap", 64'(overlap), 64'd0);
    chk("alt_p0_grants", 64'(g0), 64'd6);
    chk("alt_p1_grants", 64'(g1), 64'd6);
    auto_en = 0; hold = 0;
    tick();

    // write on port 1 with a 20-cycle wait
    mem_lat = 19;
    av_cycles = 0;
    a[1] = 13'h1FFF; wd[1] = 64'hFFFF_0000_FFFF_0000;
    rw[1] = 0; av[1] = 1;
    tick();
    chk("wr_mem_addr", 64'(mem_if.addr), 64'h1FFF);
    chk("wr_mem_wdata", mem_if.wdata, 64'hFFFF_0000_FFFF_0000);
    chk("wr_mem_rnw", 64'(mem_if.rnw), 64'd0);
    run_until(1, 1, 40);
    chk("wr_p1_rdata", p1_if.rdata, 64'd0);
    chk("wr_wait_len", 64'(av_cycles), 64'd20);
    tick();

    // reset in WAIT, then a stray ack
    mem_lat = 5;
    a[0] = 13'h155; rw[0] = 1; av[0] = 1;
    tick();
    tick();
    not_reset = 1'b0;
    #1;
    chk("rstw_mem_avalid", 64'(mem_if.avalid), 64'd0);
    chk("rstw_busy", 64'(busy), 64'd0);
    chk("rstw_mem_addr", 64'(mem_if.addr), 64'd0);
    chk("rstw_p0_grants", 64'(g0), 64'd0);
    av[0] = 0; picked = 0; mack = 0;
    tick();
    not_reset = 1'b1;
    tick();
    mack = 1;
    tick();
    chk("stray_spur", 64'(spur), 64'd1);
    chk("stray_p0_ack", 64'(p0_if.ack), 64'd0);
    tick();
    cnt_clear = 1;
    tick();
    cnt_clear = 0;
    chk("stray_cleared", 64'(spur), 64'd0);

    // saturation on the 2-bit counter instance
    auto_en = 1; hold = 1; mem_lat = 0;
    left[0] = 5; left[1] = 0;
    run_until(0, 5, 100);
    tick();
    chk("sat_w2", 64'(sg0), 64'd3);
    chk("sat_w16", 64'(g0), 64'd5);
    left[0] = 1;
    run_until(0, 1, 20);
    cnt_clear = 1;
    tick();
    cnt_clear = 0;
    chk("sat_clr_w2", 64'(sg0), 64'd0);
    chk("sat_clr_w16", 64'(g0), 64'd0);
    hold = 0;
    tick();

    // random traffic, stray acks and clears
    mem_lat = -1; spur_en = 1; clr_en = 1;
    left[0] = 150; left[1] = 150;
    b0 = ack_cnt[0];
    b1 = ack_cnt[1];
    i = 0;
    while ((ack_cnt[0] - b0 < 150 || ack_cnt[1] - b1 < 150) &&
           i < 6000) begin
      tick();
      i++;
    end
    chk("rnd_p0_acks", 64'(ack_cnt[0] - b0), 64'd150);
    chk("rnd_p1_acks", 64'(ack_cnt[1] - b1), 64'd150);
    spur_en = 0; clr_en = 0; cnt_clear = 0; auto_en = 0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
